// File: rtl/ascon_pkg.sv
// ascon_pkg: shared definitions for the ASCON substitution layer.
//   SBOX / SBOX_INV : 5-bit forward and inverse S-box tables, indexed by column value
//                     {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 is the MSB).
//   sbox_state_e    : controller states of the sequential S-box layer.
//   ASCON_W/STATE_W : word width and full permutation state width.
package ascon_pkg;

    localparam int unsigned ASCON_W = 64;
    localparam int unsigned STATE_W = 5 * ASCON_W;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [4:0] SBOX_INV [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } sbox_state_e;

endpackage

// File: rtl/ascon_sbox5.sv
// ascon_sbox5: combinational 5-bit ASCON S-box with inverse select.
//   col_i : input column {x0,x1,x2,x3,x4}, x0 in bit 4
//   inv_i : 0 = forward S-box, 1 = inverse S-box
//   col_o : substituted column, same packing
module ascon_sbox5
    import ascon_pkg::*;
(
    input  logic [4:0] col_i,
    input  logic       inv_i,
    output logic [4:0] col_o
);

    always_comb begin
        col_o = inv_i ? SBOX_INV[col_i] : SBOX[col_i];
    end

endmodule

// File: rtl/ascon_sbox_layer_seq.sv
// ascon_sbox_layer_seq: sequential ASCON substitution layer over the 320-bit state.
// Substitutes LANES bit-columns per cycle in place in a working register, then presents
// the result until the downstream handshake completes. No overlap between transactions.
//   clk_i         : rising-edge clock
//   rst_ni        : synchronous active-low reset
//   in_valid_i    : input state valid
//   in_ready_o    : block can accept a state (IDLE only)
//   in_inv_i      : 0 = forward, 1 = inverse S-box; sampled at accept
//   in_state_i    : {x0,x1,x2,x3,x4}, x0 in the MSBs
//   out_valid_o   : result valid (DONE)
//   out_ready_i   : downstream accepts result
//   out_state_o   : substituted state, same packing as in_state_i
//   busy_o        : high in BUSY or DONE
module ascon_sbox_layer_seq
    import ascon_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned W     = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic           in_inv_i,
    input  logic [5*W-1:0] in_state_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [5*W-1:0] out_state_o,
    output logic           busy_o
);

    localparam int unsigned Chunks = W / LANES;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int unsigned IdxW   = $clog2(5 * W);
    localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);

    sbox_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             inv_q, inv_d;
    logic [5*W-1:0]   work_q, work_d, work_sub;

    logic [LANES-1:0] chunk_in  [5];
    logic [LANES-1:0] chunk_out [5];
    logic [4:0]       lane_in   [LANES];
    logic [4:0]       lane_out  [LANES];
    logic [IdxW-1:0]  rd_idx, wr_idx;

    // Gather the current chunk of each word and transpose into 5-bit columns.
    always_comb begin
        rd_idx = '0;
        for (int k = 0; k < 5; k++) begin
            // Word x_k lives at bit offset (4-k)*W.
            rd_idx      = IdxW'((4 - k) * W + LANES * 32'(cnt_q));
            chunk_in[k] = work_q[rd_idx +: LANES];
        end
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = {chunk_in[0][l], chunk_in[1][l], chunk_in[2][l],
                          chunk_in[3][l], chunk_in[4][l]};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ascon_sbox5 u_sbox5 (
            .col_i (lane_in[g]),
            .inv_i (inv_q),
            .col_o (lane_out[g])
        );
    end

    // Scatter substituted columns back into the same chunk position.
    always_comb begin
        work_sub = work_q;
        wr_idx   = '0;
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < LANES; l++) begin
                chunk_out[k][l] = lane_out[l][4-k];
            end
            wr_idx                     = IdxW'((4 - k) * W + LANES * 32'(cnt_q));
            work_sub[wr_idx +: LANES] = chunk_out[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    work_d  = in_state_i;
                    inv_d   = in_inv_i;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d = work_sub;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            work_q  <= work_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign out_state_o = work_q;

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Self-checking bench for ascon_sbox_layer_seq with LANES = 1, 8 and 64 instances.
module tb_ascon_sbox_layer_seq;

    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic [319:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [319:0] out_state [3];
    logic         busy      [3];

    int errors;
    int checks;

    ascon_sbox_layer_seq #(.LANES(1), .W(64)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_inv_i(in_inv[0]),
        .in_state_i(in_state[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_state_o(out_state[0]), .busy_o(busy[0])
    );

    ascon_sbox_layer_seq #(.LANES(8), .W(64)) dut_l8 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_inv_i(in_inv[1]),
        .in_state_i(in_state[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_state_o(out_state[1]), .busy_o(busy[1])
    );

    ascon_sbox_layer_seq #(.LANES(64), .W(64)) dut_l64 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_inv_i(in_inv[2]),
        .in_state_i(in_state[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .out_state_o(out_state[2]), .busy_o(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] inv_lookup(input logic [4:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (FWD[i] == v) r = 5'(i);
        end
        return r;
    endfunction

    function automatic logic [319:0] ref_sub(input logic [319:0] st, input logic inv);
        logic [319:0] r;
        logic [4:0]   c, o;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            c = {st[256+j], st[192+j], st[128+j], st[64+j], st[j]};
            o = inv ? inv_lookup(c) : FWD[c];
            {r[256+j], r[192+j], r[128+j], r[64+j], r[j]} = o;
        end
        return r;
    endfunction

    // One full transaction; out_ready is held low for 'stall' cycles once out_valid is up.
    task automatic run_txn(input int d, input logic [319:0] st, input logic inv,
                           input int stall, output logic [319:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[d] && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("in_ready timeout", 320'(in_ready[d]), 320'(1));
        in_valid[d] = 1'b1;
        in_state[d] = st;
        in_inv[d]   = inv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state[d];
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    typedef struct {
        logic [319:0] st;
        logic         inv;
        logic [319:0] exp;
    } vec_t;

    vec_t         vecs [6];
    logic [319:0] ramp;
    logic [319:0] res, back, st, held;
    int           lat;
    int           exp_lat [3];
    int           done_cnt;
    logic         inv_r;

    initial begin
        errors     = 0;
        checks     = 0;
        exp_lat[0] = 64;
        exp_lat[1] = 8;
        exp_lat[2] = 1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_inv[d]    = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        ramp = {64'hFFFF0000FFFF0000, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0,
                64'hCCCCCCCCCCCCCCCC, 64'hAAAAAAAAAAAAAAAA};

        vecs[0] = '{st: '0, inv: 1'b0, exp: {ZERO, ZERO, ONES, ZERO, ZERO}};
        vecs[1] = '{st: '0, inv: 1'b1, exp: {ONES, ZERO, ONES, ZERO, ZERO}};
        vecs[2] = '{st: {5{ONES}}, inv: 1'b0, exp: {ONES, ZERO, ONES, ONES, ONES}};
        vecs[3] = '{st: {5{ONES}}, inv: 1'b1, exp: {ZERO, ZERO, ZERO, ONES, ZERO}};
        // Column 0 = 0x01 -> 0x0b; all other columns 0x00 -> 0x04.
        vecs[4] = '{st: {ZERO, ZERO, ZERO, ZERO, 64'h1}, inv: 1'b0,
                    exp: {ZERO, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1}};
        vecs[5] = '{st: ramp, inv: 1'b0, exp: ref_sub(ramp, 1'b0)};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset in_ready", 320'(in_ready[d]), 320'(1));
            chk("reset out_valid", 320'(out_valid[d]), 320'(0));
            chk("reset busy", 320'(busy[d]), 320'(0));
            chk("reset out_state", out_state[d], '0);
        end
        rst_n = 1'b1;

        // Directed vectors on LANES=8.
        for (int i = 0; i < 6; i++) begin
            run_txn(1, vecs[i].st, vecs[i].inv, i % 3, res, lat);
            chk($sformatf("vec%0d result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), 320'(lat), 320'(8));
        end

        // Round trip over all 32 column values for each LANES setting.
        for (int d = 0; d < 3; d++) begin
            run_txn(d, ramp, 1'b0, 0, res, lat);
            chk($sformatf("ramp fwd dut%0d", d), res, ref_sub(ramp, 1'b0));
            chk($sformatf("ramp fwd latency dut%0d", d), 320'(lat), 320'(exp_lat[d]));
            run_txn(d, res, 1'b1, 1, back, lat);
            chk($sformatf("ramp roundtrip dut%0d", d), back, ramp);
            chk($sformatf("ramp inv latency dut%0d", d), 320'(lat), 320'(exp_lat[d]));
        end

        // Backpressure: hold DONE for 5 cycles with a competing in_valid.
        in_valid[1] = 1'b1;
        in_state[1] = '0;
        in_inv[1]   = 1'b0;
        @(posedge clk); #1;
        in_state[1] = {5{ONES}};
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid up", 320'(out_valid[1]), 320'(1));
        held = out_state[1];
        chk("bp result", held, {ZERO, ZERO, ONES, ZERO, ZERO});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp out_valid hold", 320'(out_valid[1]), 320'(1));
            chk("bp out_state hold", out_state[1], held);
            chk("bp in_ready low", 320'(in_ready[1]), 320'(0));
            chk("bp busy", 320'(busy[1]), 320'(1));
        end
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b0;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        chk("bp release in_ready", 320'(in_ready[1]), 320'(1));
        chk("bp release out_valid", 320'(out_valid[1]), 320'(0));
        @(posedge clk); #1;
        chk("bp no stray accept", 320'(busy[1]), 320'(0));

        // Reset while BUSY with cnt = 3.
        in_valid[1] = 1'b1;
        in_state[1] = {5{ONES}};
        in_inv[1]   = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst busy before", 320'(busy[1]), 320'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst in_ready", 320'(in_ready[1]), 320'(1));
        chk("midrst out_valid", 320'(out_valid[1]), 320'(0));
        chk("midrst busy", 320'(busy[1]), 320'(0));
        chk("midrst out_state", out_state[1], '0);
        run_txn(1, '0, 1'b0, 0, res, lat);
        chk("post-reset result", res, {ZERO, ZERO, ONES, ZERO, ZERO});
        chk("post-reset latency", 320'(lat), 320'(8));

        // Random regression with stalls.
        done_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int w = 0; w < 10; w++) st[w*32 +: 32] = $urandom;
            inv_r = 1'($urandom_range(0, 1));
            run_txn(1, st, inv_r, $urandom_range(0, 3), res, lat);
            if (lat == 8) done_cnt++;
            chk("random result", res, ref_sub(st, inv_r));
            chk("random no duplicate", 320'(out_valid[1]), 320'(0));
        end
        chk("random completions", 320'(done_cnt), 320'(1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
